// File: rtl/memory_pkg.sv
// Shared memory-port definitions: bus widths, access-size codes and the
// arbiter owner encoding used by mem_port_arbiter.
package memory_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_WORD_WIDTH = 32;

    // n_bytes code for a full-word access
    localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

    // Which requester owns the response arriving in the current cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory load/store port between instruction
// fetch (if_*) and the load-store unit (ls_*). Load-store has priority, but
// fetch is guaranteed a grant after MAX_WAIT consecutive denied cycles.
// Grants and the m_* request mux are combinational; responses are steered to
// the requester granted in the previous cycle.
//   clk, rst                 : clock, synchronous active-high reset
//   if_req/if_addr/if_gnt    : fetch request channel
//   if_rvalid/rdata/addr_err : fetch response
//   ls_req/write_en/...      : load-store request channel, ls_gnt
//   ls_rvalid/rdata/addr_err : load-store response
//   m_*                      : shared memory port request/response
module mem_port_arbiter
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_WIDTH,
    parameter int unsigned WORD_W   = MEM_WORD_WIDTH,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_addr_err,

    input  logic              ls_req,
    input  logic              ls_write_en,
    input  logic              ls_l_unsigned,
    input  logic [1:0]        ls_n_bytes,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [WORD_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [WORD_W-1:0] ls_rdata,
    output logic              ls_addr_err,

    output logic              m_req,
    output logic              m_write_en,
    output logic              m_l_unsigned,
    output logic [1:0]        m_n_bytes,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic              m_addr_err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    owner_e           owner;
    owner_e           owner_nxt;
    logic             fetch_starved;

    assign fetch_starved = if_req && (wait_cnt == WAIT_LIMIT);

    // Grant selection: load-store first unless fetch has waited too long
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if (if_req && (fetch_starved || !ls_req)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    // Shared port request mux; fetch always issues a plain word read
    always_comb begin
        m_req        = if_gnt | ls_gnt;
        m_write_en   = 1'b0;
        m_l_unsigned = 1'b0;
        m_n_bytes    = 2'b00;
        m_addr       = '0;
        m_wdata      = '0;
        if (if_gnt) begin
            m_n_bytes = MEM_SIZE_WORD;
            m_addr    = if_addr;
        end else if (ls_gnt) begin
            m_write_en   = ls_write_en;
            m_l_unsigned = ls_l_unsigned;
            m_n_bytes    = ls_n_bytes;
            m_addr       = ls_addr;
            m_wdata      = ls_wdata;
        end
    end

    // Next owner and fetch starvation counter
    always_comb begin
        owner_nxt    = OWN_NONE;
        wait_cnt_nxt = '0;
        if (if_gnt) begin
            owner_nxt = OWN_IF;
        end else if (ls_gnt) begin
            owner_nxt = OWN_LS;
        end
        if (if_req && !if_gnt) begin
            wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_NONE;
            wait_cnt <= '0;
        end else begin
            owner    <= owner_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Response steering; reset masks a response that was in flight
    always_comb begin
        if_rvalid   = !rst && (owner == OWN_IF);
        ls_rvalid   = !rst && (owner == OWN_LS);
        if_rdata    = if_rvalid ? m_rdata : '0;
        if_addr_err = if_rvalid ? m_addr_err : 1'b0;
        ls_rdata    = ls_rvalid ? m_rdata : '0;
        ls_addr_err = ls_rvalid ? m_addr_err : 1'b0;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, byte address width.
REQ-002 Parameter WORD_W, default memory_pkg::MEM_WORD_WIDTH, data width.
REQ-003 Parameter MAX_WAIT, default 4, max consecutive cycles fetch may be denied while requesting; legal range 1..15.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req / if_addr  in  1 / ADDR_W  fetch request, address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid / if_rdata / if_addr_err  out  1 / WORD_W / 1  fetch response.
REQ-009 ls_req / ls_write_en / ls_l_unsigned  in  1 / 1 / 1  load-store request, store select, unsigned-load select.
REQ-010 ls_n_bytes / ls_addr / ls_wdata  in  2 / ADDR_W / WORD_W  access size code, address, store data.
REQ-011 ls_gnt  out  1  load-store request accepted this cycle.
REQ-012 ls_rvalid / ls_rdata / ls_addr_err  out  1 / WORD_W / 1  load-store response.
REQ-013 m_req / m_write_en / m_l_unsigned / m_n_bytes / m_addr / m_wdata  out  1 / 1 / 1 / 2 / ADDR_W / WORD_W  shared memory port, mem_read_write field semantics.
REQ-014 m_rdata / m_addr_err  in  WORD_W / 1  shared port response, valid one cycle after m_req.

Function
REQ-015 Requesters SHALL hold req and all request fields stable until the cycle their gnt is high.
REQ-016 At most one of if_gnt, ls_gnt SHALL be high per cycle; gnt is combinational from req and arbiter state.
REQ-017 Default priority: ls_req wins over if_req.
REQ-018 wait_cnt (4 bits) SHALL increment each cycle if_req=1 and if_gnt=0, clear on if_gnt or if_req=0, saturate at MAX_WAIT.
REQ-019 When wait_cnt==MAX_WAIT and if_req=1, fetch SHALL win and ls_gnt=0 that cycle.
REQ-020 m_req SHALL equal if_gnt|ls_gnt; m_* fields SHALL be a combinational mux of the granted requester.
REQ-021 When fetch is granted: m_write_en=0, m_l_unsigned=0, m_n_bytes=2'b11 (word), m_wdata=0.
REQ-022 No request: m_req=0, all m_* fields 0.
REQ-023 Owner register, states NONE/IF/LS, SHALL load IF on if_gnt, LS on ls_gnt, else NONE, every cycle.
REQ-024 One cycle after a grant, owner's rvalid=1 with rdata=m_rdata, addr_err=m_addr_err; other requester's rvalid=0, rdata=0, addr_err=0.
REQ-025 ls_rvalid SHALL also pulse for stores (write acknowledge), ls_rdata don't-care then.
REQ-026 Back-to-back grants SHALL be allowed every cycle; throughput one access per cycle, latency grant-to-rvalid exactly 1 cycle.
REQ-027 Simultaneous continuous ls_req and if_req: pattern SHALL be MAX_WAIT ls grants then 1 if grant, repeating.
REQ-028 m_addr_err on a response SHALL be forwarded only; arbiter state is not altered by errors.

Reset
REQ-029 While rst=1: owner=NONE, wait_cnt=0, if_gnt=ls_gnt=0, m_req=0, all rvalid/addr_err=0, rdata=0.
REQ-030 Reset asserted with a response pending SHALL drop that response; no rvalid in the cycle after rst deasserts.
REQ-031 First cycle after rst deasserts SHALL arbitrate normally.

Structure
REQ-032 Owner enum (NONE/IF/LS) and word-size code constant SHALL live in memory_pkg.
REQ-033 Single flat module; no sub-module required; instantiated between core fetch/LSU and Memory load_store_port.

Verification
REQ-034 ls_req only, load addr 0x4000 -> ls_gnt same cycle, ls_rvalid next cycle, ls_rdata=m_rdata, if_rvalid=0.
REQ-035 if_req and ls_req held high 20 cycles, MAX_WAIT=4 -> grants LLLLI repeating, no cycle with both gnt.
REQ-036 ls store 0x4004 data 0xDEADBEEF -> m_write_en=1, m_wdata=0xDEADBEEF, ls_rvalid 1 cycle later.
REQ-037 Fetch 0x0010 with m_addr_err=1 on response -> if_rvalid=1, if_addr_err=1, next fetch granted normally.
REQ-038 rst asserted the cycle after ls_gnt -> ls_rvalid stays 0, wait_cnt=0, all outputs zero.
REQ-039 if_req alone every cycle 8 cycles -> if_gnt every cycle, 8 if_rvalid pulses, wait_cnt stays 0.
